nfca_rx_window_ctrl: RTL
========================

# nfca_rx_window_ctrl

Receive-window sequencer for the NFC-A PCD receive path. It sits between the ASK-detect DSP (2.5425 Msa/s `rx_ask_en`/`rx_ask` stream) and the downstream bit/frame decoder. It tracks PCD transmission, flushes the DSP history after TX, blanks the frame-delay guard interval, and opens the receive window. It detects PICC start-of-response, end-of-response (carrier-idle) and no-response timeout, and gates the ASK stream so the decoder sees only in-window samples.

## Interface
- `GUARD_SAMPLES`, default 160: `rx_ask_en` ticks blanked after TX ends (≈63 µs). Legal range 1..4095.
- `TIMEOUT_SAMPLES`, default 2048: ticks in LISTEN before timeout (≈805 µs). Legal range 1..4095.
- `EOF_SAMPLES`, default 48: consecutive `rx_ask=0` ticks ending a response (2 bit times at 106 kbps, 24 samples/bit). Legal range 1..4095.
- `rstn` input 1: asynchronous, active-low reset.
- `clk` input 1: system clock, 81.36 MHz.
- `tx_busy` input 1: level; high while PCD modulates the field.
- `rx_ask_en` input 1: one-cycle sample strobe from the DSP.
- `rx_ask` input 1: DSP ASK decision, valid with `rx_ask_en`.
- `dsp_clr` output 1: one-cycle pulse instructing the DSP to flush history/warm-up.
- `out_ask_en` output 1: gated sample strobe to the decoder.
- `out_ask` output 1: gated ASK value; held when `out_ask_en`=0.
- `rx_busy` output 1: high in GUARD, LISTEN or RECV.
- `rx_start` output 1: one-cycle pulse on the first in-window `rx_ask=1`.
- `rx_end` output 1: one-cycle pulse on EOF detection.
- `rx_timeout` output 1: one-cycle pulse on LISTEN expiry.

## Operation
- States: IDLE, TX, GUARD, LISTEN, RECV.
- All outputs reset to 0. State resets to IDLE. Counters reset to 0.
- **tx_busy override.** `tx_busy`=1 in any state moves the FSM to TX on the next edge. No `rx_end`/`rx_timeout` pulse is emitted. Gating closes that same edge.
- **TX.** On `tx_busy`=0, move to GUARD, pulse `dsp_clr` for one cycle and clear the counter.
- **GUARD.** Count `rx_ask_en` ticks and ignore `rx_ask`. At count == `GUARD_SAMPLES`, move to LISTEN and clear the counter.
- **LISTEN.** Count ticks.
  - On a tick with `rx_ask`=1: pulse `rx_start`, enter RECV, clear the counter, and forward this sample.
  - On a tick with `rx_ask`=0 where the count reaches `TIMEOUT_SAMPLES`: pulse `rx_timeout` and go to IDLE.
  - `rx_ask`=1 takes priority over timeout on the same tick.
- **RECV.** Forward every tick.
  - `rx_ask`=1 clears the idle counter.
  - `rx_ask`=0 increments it.
  - When the counter reaches `EOF_SAMPLES`: forward that sample, pulse `rx_end`, go to IDLE.
- **IDLE.** Wait for `tx_busy`=1. Ticks are ignored.
- **Counter.** One shared 12-bit counter; compare is equality after increment; no wrap is reachable within legal parameter ranges.
- **Forwarding.** A tick received in a forwarding state sets `out_ask_en`=1 for one cycle and `out_ask`=`rx_ask`. Forwarding states are the LISTEN start tick and all RECV ticks.

## Timing
- Every output is registered.
- `out_ask_en`/`out_ask`: 1 cycle after the `rx_ask_en` cycle.
- `rx_start`, `rx_end` and `rx_timeout` coincide with `out_ask_en` of the deciding tick. `rx_timeout` has no `out_ask_en`.
- `dsp_clr`: 1 cycle after the `tx_busy` falling edge is sampled.
- `rx_busy`: rises the same edge as `dsp_clr`; falls the same edge as `rx_end`/`rx_timeout`, or on the TX override.
- Minimum cycles from `tx_busy` low to first forwarded sample: 1 + `GUARD_SAMPLES` ticks + 1 tick.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0 immediately.

## Configuration
- Macro: `NFCA_RX_TIMEOUT_EN`.
- **Defined:** LISTEN expiry behaves as described.
- **Undefined:** the timeout compare is removed. LISTEN waits indefinitely for a response or `tx_busy`. `rx_timeout` is tied to 0. `TIMEOUT_SAMPLES` is ignored.

## Test plan
- **Reset:** `rstn`=0 mid-RECV → all outputs 0 at once; state IDLE after release; no pulses until the next `tx_busy`.
- **Normal response:** `tx_busy` pulse, then 160 ticks of `rx_ask`=0, then `rx_ask`=1 on tick 161.
  - `dsp_clr` is one cycle.
  - `rx_start` with the first `out_ask_en`.
  - Guard ticks are never forwarded.
- **EOF:** in RECV, pattern 1,0×47,1 then 0×48.
  - No `rx_end` after the 47-zero run.
  - `rx_end` on the 48th zero of the final run, together with the last `out_ask_en`.
  - `rx_busy` falls on the same edge.
- **Timeout (macro defined):** 2048 LISTEN ticks of `rx_ask`=0 → `rx_timeout` on tick 2048; no `out_ask_en` emitted. Variant: `rx_ask`=1 exactly on tick 2048 → `rx_start`, no `rx_timeout`.
- **Timeout (macro undefined):** 5000 LISTEN ticks of 0 → `rx_timeout` stays 0 and `rx_busy` stays 1.
- **TX override:** `tx_busy`=1 during RECV → gating stops next edge; no `rx_end`. After `tx_busy` falls, a new `dsp_clr` and full guard follow.

Source files
------------

// File: rtl/nfca_rx_window_ctrl.sv
// NFC-A PCD receive-window sequencer: tracks TX, flushes the DSP, blanks the guard interval, and gates the ASK stream.
// Optional build macro NFCA_RX_TIMEOUT_EN enables the LISTEN no-response timeout.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for the PCD to start transmitting; ticks ignored
// TX     | PCD modulating the field
// GUARD  | frame-delay blanking, counting ticks after TX ends
// LISTEN | window open, waiting for PICC start-of-response
// RECV   | forwarding response samples, watching for carrier-idle EOF
module nfca_rx_window_ctrl #(
  parameter int GUARD_SAMPLES   = 160,
  parameter int TIMEOUT_SAMPLES = 2048,
  parameter int EOF_SAMPLES     = 48
) (
  input  logic clk,
  input  logic rstn,
  input  logic tx_busy,
  input  logic rx_ask_en,
  input  logic rx_ask,
  output logic dsp_clr,
  output logic out_ask_en,
  output logic out_ask,
  output logic rx_busy,
  output logic rx_start,
  output logic rx_end,
  output logic rx_timeout
);

  localparam logic [11:0] GUARD_CNT   = 12'(GUARD_SAMPLES);
  localparam logic [11:0] TIMEOUT_CNT = 12'(TIMEOUT_SAMPLES);
  localparam logic [11:0] EOF_CNT     = 12'(EOF_SAMPLES);

`ifdef NFCA_RX_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_GUARD,
    S_LISTEN,
    S_RECV
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d, cnt_inc;
  logic        timeout_hit;
  logic        dsp_clr_d, out_ask_en_d, out_ask_d, rx_busy_d;
  logic        rx_start_d, rx_end_d, rx_timeout_d;

  assign cnt_inc = cnt_q + 12'd1;
  // With the timeout disabled the compare is constant-false and folds away.
  assign timeout_hit = TIMEOUT_EN && (cnt_inc == TIMEOUT_CNT);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dsp_clr_d    = 1'b0;
    out_ask_en_d = 1'b0;
    out_ask_d    = out_ask;
    rx_start_d   = 1'b0;
    rx_end_d     = 1'b0;
    rx_timeout_d = 1'b0;

    if (tx_busy) begin
      state_d = S_TX;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_TX: begin
          state_d   = S_GUARD;
          cnt_d     = 12'd0;
          dsp_clr_d = 1'b1;
        end
        S_GUARD: begin
          if (rx_ask_en) begin
            cnt_d = cnt_inc;
            if (cnt_inc == GUARD_CNT) begin
              state_d = S_LISTEN;
              cnt_d   = 12'd0;
            end
          end
        end
        S_LISTEN: begin
          if (rx_ask_en) begin
            cnt_d = cnt_inc;
            if (rx_ask) begin
              state_d      = S_RECV;
              cnt_d        = 12'd0;
              rx_start_d   = 1'b1;
              out_ask_en_d = 1'b1;
              out_ask_d    = 1'b1;
            end else if (timeout_hit) begin
              state_d      = S_IDLE;
              rx_timeout_d = 1'b1;
            end
          end
        end
        S_RECV: begin
          if (rx_ask_en) begin
            out_ask_en_d = 1'b1;
            out_ask_d    = rx_ask;
            if (rx_ask) begin
              cnt_d = 12'd0;
            end else begin
              cnt_d = cnt_inc;
              if (cnt_inc == EOF_CNT) begin
                state_d  = S_IDLE;
                rx_end_d = 1'b1;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    rx_busy_d = (state_d == S_GUARD) || (state_d == S_LISTEN) || (state_d == S_RECV);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 12'd0;
      dsp_clr    <= 1'b0;
      out_ask_en <= 1'b0;
      out_ask    <= 1'b0;
      rx_busy    <= 1'b0;
      rx_start   <= 1'b0;
      rx_end     <= 1'b0;
      rx_timeout <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dsp_clr    <= dsp_clr_d;
      out_ask_en <= out_ask_en_d;
      out_ask    <= out_ask_d;
      rx_busy    <= rx_busy_d;
      rx_start   <= rx_start_d;
      rx_end     <= rx_end_d;
      rx_timeout <= rx_timeout_d;
    end
  end

endmodule
